adc_spi_frame_rx: RTL

SPI master front end for the 8-channel biopotential ADC (ADS1299-style continuous read). It waits for the ADC's data-ready falling edge, then clocks out one frame: a 24-bit status word followed by N_CH 24-bit channel words. Each channel word is presented as a single-cycle sample strobe with its channel index. The outputs drive the pipeline top's raw_adc_in, adc_channel_sel and adc_data_ready inputs directly, upstream of feature extraction.

---
 rtl/adc_spi_frame_rx.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/adc_spi_frame_rx.sv
// SPI master front end for an ADS1299-style ADC in continuous-read mode.
// Waits for a DRDY falling edge, then reads one status word plus N_CH channel words.
`timescale 1ns/1ps

module adc_spi_frame_rx #(
    parameter int unsigned SCLK_DIV  = 4,
    parameter int unsigned N_CH      = 8,
    parameter int unsigned WORD_BITS = 24
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic                 drdy_n,
    input  logic                 miso,
    output logic                 sclk,
    output logic                 cs_n,
    output logic [WORD_BITS-1:0] sample_out,
    output logic [2:0]           ch_out,
    output logic                 sample_valid,
    output logic [WORD_BITS-1:0] status_word,
    output logic                 status_valid,
    output logic                 busy,
    output logic                 overrun,
    output logic [7:0]           overrun_count
);

    localparam int unsigned DivW  = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
    localparam int unsigned BitW  = (WORD_BITS > 1) ? $clog2(WORD_BITS) : 1;
    localparam int unsigned WordW = $clog2(N_CH + 1);

    typedef enum logic [1:0] {StIdle, StCsSetup, StShift, StCsHold} state_e;

    state_e                 state_q, state_d;
    logic [DivW-1:0]        div_q, div_d;
    logic [BitW-1:0]        bit_q, bit_d;
    logic [WordW-1:0]       word_q, word_d;
    logic [WORD_BITS-2:0]   shift_q, shift_d;
    logic                   sclk_q, sclk_d;
    logic                   cs_n_q, cs_n_d;
    logic                   last_q, last_d;
    logic [WORD_BITS-1:0]   sample_q, sample_d;
    logic [2:0]             ch_q, ch_d;
    logic                   sample_valid_q, sample_valid_d;
    logic [WORD_BITS-1:0]   status_q, status_d;
    logic                   status_valid_q, status_valid_d;
    logic                   overrun_q, overrun_d;
    logic [7:0]             overrun_count_q, overrun_count_d;

    // Two sync stages plus one history stage; all reset high so reset never fakes an edge.
    logic drdy_s1_q, drdy_s2_q, drdy_s3_q;
    logic drdy_edge;
    logic div_end;
    logic [WORD_BITS-1:0] word_bits;

    assign drdy_edge = drdy_s3_q & ~drdy_s2_q;
    assign div_end   = (div_q == DivW'(SCLK_DIV - 1));
    assign word_bits = {shift_q, miso};

    always_comb begin
        state_d         = state_q;
        div_d           = div_q;
        bit_d           = bit_q;
        word_d          = word_q;
        shift_d         = shift_q;
        sclk_d          = sclk_q;
        cs_n_d          = cs_n_q;
        last_d          = last_q;
        sample_d        = sample_q;
        ch_d            = ch_q;
        sample_valid_d  = 1'b0;
        status_d        = status_q;
        status_valid_d  = 1'b0;
        overrun_d       = 1'b0;
        overrun_count_d = overrun_count_q;

        if (drdy_edge && (state_q != StIdle)) begin
            overrun_d = 1'b1;
            if (overrun_count_q != 8'hFF) begin
                overrun_count_d = overrun_count_q + 8'd1;
            end
        end

        unique case (state_q)
            StIdle: begin
                if (drdy_edge && enable) begin
                    state_d = StCsSetup;
                    cs_n_d  = 1'b0;
                    div_d   = '0;
                    bit_d   = '0;
                    word_d  = '0;
                    last_d  = 1'b0;
                end
            end
            StCsSetup: begin
                if (div_end) begin
                    div_d   = '0;
                    sclk_d  = 1'b1;
                    state_d = StShift;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            StShift: begin
                if (!div_end) begin
                    div_d = div_q + 1'b1;
                end else begin
                    div_d = '0;
                    if (sclk_q) begin
                        // Falling SCLK edge: ADC data is stable, capture it.
                        sclk_d  = 1'b0;
                        shift_d = word_bits[WORD_BITS-2:0];
                        if (bit_q == BitW'(WORD_BITS - 1)) begin
                            bit_d  = '0;
                            word_d = word_q + 1'b1;
                            if (word_q == '0) begin
                                status_d       = word_bits;
                                status_valid_d = 1'b1;
                            end else begin
                                sample_d       = word_bits;
                                ch_d           = 3'(word_q - 1'b1);
                                sample_valid_d = 1'b1;
                            end
                            if (word_q == WordW'(N_CH)) begin
                                last_d = 1'b1;
                            end
                        end else begin
                            bit_d = bit_q + 1'b1;
                        end
                    end else if (last_q) begin
                        // Final low half-period done; no further rising edge.
                        state_d = StCsHold;
                    end else begin
                        sclk_d = 1'b1;
                    end
                end
            end
            StCsHold: begin
                if (div_end) begin
                    div_d   = '0;
                    cs_n_d  = 1'b1;
                    state_d = StIdle;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            drdy_s1_q       <= 1'b1;
            drdy_s2_q       <= 1'b1;
            drdy_s3_q       <= 1'b1;
            state_q         <= StIdle;
            div_q           <= '0;
            bit_q           <= '0;
            word_q          <= '0;
            shift_q         <= '0;
            sclk_q          <= 1'b0;
            cs_n_q          <= 1'b1;
            last_q          <= 1'b0;
            sample_q        <= '0;
            ch_q            <= '0;
            sample_valid_q  <= 1'b0;
            status_q        <= '0;
            status_valid_q  <= 1'b0;
            overrun_q       <= 1'b0;
            overrun_count_q <= '0;
        end else begin
            drdy_s1_q       <= drdy_n;
            drdy_s2_q       <= drdy_s1_q;
            drdy_s3_q       <= drdy_s2_q;
            state_q         <= state_d;
            div_q           <= div_d;
            bit_q           <= bit_d;
            word_q          <= word_d;
            shift_q         <= shift_d;
            sclk_q          <= sclk_d;
            cs_n_q          <= cs_n_d;
            last_q          <= last_d;
            sample_q        <= sample_d;
            ch_q            <= ch_d;
            sample_valid_q  <= sample_valid_d;
            status_q        <= status_d;
            status_valid_q  <= status_valid_d;
            overrun_q       <= overrun_d;
            overrun_count_q <= overrun_count_d;
        end
    end

    assign sclk          = sclk_q;
    assign cs_n          = cs_n_q;
    assign sample_out    = sample_q;
    assign ch_out        = ch_q;
    assign sample_valid  = sample_valid_q;
    assign status_word   = status_q;
    assign status_valid  = status_valid_q;
    assign busy          = (state_q != StIdle);
    assign overrun       = overrun_q;
    assign overrun_count = overrun_count_q;

endmodule
